// File: rtl/samp_rate_scheduler.sv
// samp_rate_scheduler: picks one of eight sample-rate square waves and turns each rising
// edge of the selected wave into a single request/acknowledge transaction. Rate changes
// are deferred to a one-clock SWITCH state, and overruns and ack timeouts are reported.
// Optional feature: define SAMP_SCHED_SEQ_EN to build the 16-bit request sequence counter;
// without it sample_seq is tied to zero.
module samp_rate_scheduler #(
    parameter int unsigned OVR_W       = 8,
    parameter int unsigned ACK_TIMEOUT = 1023,
    parameter int unsigned RATE_RST    = 7
) (
    input  logic             clock_in,
    input  logic             reset_btn,
    input  logic [7:0]       samp_rates,
    input  logic             enable,
    input  logic [2:0]       rate_sel,
    input  logic             rate_wr,
    input  logic             sample_ack,
    input  logic             err_clr,
    output logic             sample_req,
    output logic [2:0]       active_rate,
    output logic             rate_pending,
    output logic [OVR_W-1:0] ovr_cnt,
    output logic             ovr_flag,
    output logic             tmo_flag,
    output logic [15:0]      sample_seq
);

    // Counter holds completed REQ clocks, so it only needs to reach ACK_TIMEOUT-1.
    localparam int unsigned     TMO_W      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned     TMO_LAST   = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;
    localparam logic [TMO_W-1:0] TMO_LAST_V = TMO_LAST[TMO_W-1:0];
    localparam logic [2:0]       RATE_RST_V = RATE_RST[2:0];
    localparam logic [OVR_W-1:0] OVR_MAX    = '1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StSwitch
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic             r_prev_bit;
    logic             w_prev_bit_d;
    logic [2:0]       r_active_rate;
    logic [2:0]       r_pend_rate;
    logic             r_rate_pending;
    logic [OVR_W-1:0] r_ovr_cnt;
    logic             r_ovr_flag;
    logic             r_tmo_flag;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_tick;
    logic             w_tmo_hit;
    logic             w_start;
    logic             w_ovr;
    logic             w_tmo;

    // Edge detect on the selected wave; masked while disabled or mid-switch.
    assign w_tick = samp_rates[r_active_rate] & ~r_prev_bit & enable & (r_state != StSwitch);

    assign w_tmo_hit = (ACK_TIMEOUT != 0) && (r_tmo_cnt == TMO_LAST_V);

    // During SWITCH, preload the edge detector from the new wave to avoid a false edge.
    assign w_prev_bit_d = (r_state == StSwitch) ? samp_rates[r_pend_rate]
                                                : samp_rates[r_active_rate];

    // Next-state and per-clock events of the transaction FSM.
    always_comb begin
        w_state_d = r_state;
        w_start   = 1'b0;
        w_ovr     = 1'b0;
        w_tmo     = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_tick) begin
                    w_state_d = StReq;
                    w_start   = 1'b1;
                end else if (r_rate_pending) begin
                    w_state_d = StSwitch;
                end
            end
            StReq: begin
                if (sample_ack) begin
                    // Ack and a fresh edge together: start the next transaction in place.
                    if (w_tick) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else begin
                    if (w_tick) begin
                        w_ovr = 1'b1;
                    end
                    if (w_tmo_hit) begin
                        w_tmo     = 1'b1;
                        w_state_d = StIdle;
                    end
                end
            end
            StSwitch: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // FSM state, edge-detector history and the rate in use.
    always_ff @(posedge clock_in or posedge reset_btn) begin
        if (reset_btn) begin
            r_state       <= StIdle;
            // Reset high so the first clock after release can never see an edge.
            r_prev_bit    <= 1'b1;
            r_active_rate <= RATE_RST_V;
        end else begin
            r_state    <= w_state_d;
            r_prev_bit <= w_prev_bit_d;
            if (r_state == StSwitch) begin
                r_active_rate <= r_pend_rate;
            end
        end
    end

    // Pending rate write; a write coinciding with SWITCH stays pending for the next switch.
    always_ff @(posedge clock_in or posedge reset_btn) begin
        if (reset_btn) begin
            r_pend_rate    <= RATE_RST_V;
            r_rate_pending <= 1'b0;
        end else if (rate_wr) begin
            r_pend_rate    <= rate_sel;
            r_rate_pending <= 1'b1;
        end else if (r_state == StSwitch) begin
            r_rate_pending <= 1'b0;
        end
    end

    // Ack timeout counter, restarted on every new request.
    always_ff @(posedge clock_in or posedge reset_btn) begin
        if (reset_btn) begin
            r_tmo_cnt <= '0;
        end else if (w_start) begin
            r_tmo_cnt <= '0;
        end else if (r_state == StReq) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Error reporting; an event coinciding with err_clr survives the clear.
    always_ff @(posedge clock_in or posedge reset_btn) begin
        if (reset_btn) begin
            r_ovr_cnt  <= '0;
            r_ovr_flag <= 1'b0;
            r_tmo_flag <= 1'b0;
        end else if (err_clr) begin
            r_ovr_cnt  <= w_ovr ? {{(OVR_W-1){1'b0}}, 1'b1} : '0;
            r_ovr_flag <= w_ovr;
            r_tmo_flag <= w_tmo;
        end else begin
            if (w_ovr && (r_ovr_cnt != OVR_MAX)) begin
                r_ovr_cnt <= r_ovr_cnt + 1'b1;
            end
            r_ovr_flag <= r_ovr_flag | w_ovr;
            r_tmo_flag <= r_tmo_flag | w_tmo;
        end
    end

`ifdef SAMP_SCHED_SEQ_EN
    logic [15:0] r_seq;

    // Sequence number bumps on every new transaction, wrapping naturally.
    always_ff @(posedge clock_in or posedge reset_btn) begin
        if (reset_btn) begin
            r_seq <= '0;
        end else if (w_start) begin
            r_seq <= r_seq + 16'd1;
        end
    end

    assign sample_seq = r_seq;
`else
    assign sample_seq = '0;
`endif

    assign sample_req   = (r_state == StReq);
    assign active_rate  = r_active_rate;
    assign rate_pending = r_rate_pending;
    assign ovr_cnt      = r_ovr_cnt;
    assign ovr_flag     = r_ovr_flag;
    assign tmo_flag     = r_tmo_flag;

endmodule
